// File: rtl/riscv_perf_pkg.sv
// Shared types and constants for the cycle-count UART reporter.
package riscv_perf_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_FIN} rpt_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int REPORT_BYTES = 10;

  // Uppercase hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F'.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/riscv_perf_uart_reporter_uart_tx_byte.sv
// 8N1 UART transmitter for a single byte; start_i is ignored while a frame is in flight.
// state    | meaning
// TX_IDLE  | line high, waiting for start_i
// TX_START | start bit (0)
// TX_DATA  | 8 data bits, LSB first
// TX_STOP  | stop bit (1); done_o high in its last cycle
module uart_tx_byte
  import riscv_perf_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_TC  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE = BW'(1);

  tx_state_t   r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_done;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= TX_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          if (start_i) begin
            r_shift <= data_i;
            r_tx    <= 1'b0;
            r_baud  <= BAUD_TC;
            r_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_baud == '0) begin
            r_tx    <= r_shift[0];
            r_baud  <= BAUD_TC;
            r_bit   <= '0;
            r_state <= TX_DATA;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        TX_DATA: begin
          if (r_baud == '0) begin
            r_baud <= BAUD_TC;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= TX_STOP;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        TX_STOP: begin
          // Raise done one cycle early so the registered pulse lands in the last stop cycle.
          if (r_baud == BAUD_ONE) r_done <= 1'b1;
          if (r_baud == '0) r_state <= TX_IDLE;
          else r_baud <= r_baud - 1'b1;
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  assign tx_o   = r_tx;
  assign busy_o = (r_state != TX_IDLE);
  assign done_o = r_done;

endmodule

// File: rtl/riscv_perf_uart_reporter.sv
// Latches the cycle count on a rising measurement_done_i and prints it as 8 hex digits plus CR LF.
// state   | meaning
// ST_IDLE | waiting for a rising edge on measurement_done_i
// ST_LOAD | hand the current report byte to the transmitter
// ST_SEND | wait for the transmitter to finish that byte
// ST_FIN  | one-cycle report_done_o pulse, then back to idle
module riscv_perf_uart_reporter
  import riscv_perf_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] cycle_count_i,
  input  logic        measurement_done_i,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        report_done_o
);

  localparam int NUM_DIGITS = 8;

  rpt_state_t r_state;
  logic        r_done_q;
  logic [31:0] r_cnt;
  logic [3:0]  r_byte_idx;
  logic        r_busy;
  logic        r_report_done;
  logic        r_tx_start;
  logic [7:0]  r_tx_data;

  logic [7:0][3:0] w_nibs;
  logic [3:0]  w_nibble;
  logic [7:0]  w_byte;
  logic        w_trigger;
  logic        w_tx_busy;
  logic        w_tx_done;

  assign w_nibs    = r_cnt;
  assign w_nibble  = w_nibs[3'd7 - r_byte_idx[2:0]];
  assign w_trigger = measurement_done_i & ~r_done_q;

  always_comb begin
    w_byte = ASCII_LF;
    if (r_byte_idx < 4'(NUM_DIGITS)) w_byte = nibble_to_ascii(w_nibble);
    else if (r_byte_idx == 4'(NUM_DIGITS)) w_byte = ASCII_CR;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state       <= ST_IDLE;
      r_done_q      <= 1'b0;
      r_cnt         <= '0;
      r_byte_idx    <= '0;
      r_busy        <= 1'b0;
      r_report_done <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
    end else begin
      r_done_q      <= measurement_done_i;
      r_tx_start    <= 1'b0;
      r_report_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_cnt      <= cycle_count_i;
            r_byte_idx <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!w_tx_busy) begin
            r_tx_data  <= w_byte;
            r_tx_start <= 1'b1;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_tx_done) begin
            if (r_byte_idx == 4'(REPORT_BYTES - 1)) begin
              r_report_done <= 1'b1;
              r_state       <= ST_FIN;
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
              r_state    <= ST_LOAD;
            end
          end
        end
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .start_i(r_tx_start),
    .data_i (r_tx_data),
    .tx_o   (uart_tx_o),
    .busy_o (w_tx_busy),
    .done_o (w_tx_done)
  );

  assign busy_o        = r_busy;
  assign report_done_o = r_report_done;

endmodule

// File: tb/tb_riscv_perf_uart_reporter.sv
// Directed bench for the cycle-count UART reporter: instance A at 4 clocks/bit, instance B at 868.
module tb_riscv_perf_uart_reporter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, done_a, tx_a, busy_a, rd_a;
  logic        rst_b, done_b, tx_b, busy_b, rd_b;
  logic [31:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_pulses = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (rd_a === 1'b1) rd_pulses++;

  riscv_perf_uart_reporter #(.CLKS_PER_BIT(4)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .cycle_count_i(cnt_a), .measurement_done_i(done_a),
    .uart_tx_o(tx_a), .busy_o(busy_a), .report_done_o(rd_a)
  );

  riscv_perf_uart_reporter #(.CLKS_PER_BIT(868)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .cycle_count_i(cnt_b), .measurement_done_i(done_b),
    .uart_tx_o(tx_b), .busy_o(busy_b), .report_done_o(rd_b)
  );

  logic [7:0] got [10];
  int   gidle [10];
  int   gferr [10];
  int   t_first, t_done;
  logic busy_first, rd_at_done, rd_after, busy_after;

  function automatic logic line_of(input int sel);
    return (sel != 0) ? tx_b : tx_a;
  endfunction

  // Receives one frame; ferr=1 for a malformed bit, 2 for no start bit within the time limit.
  task automatic rx_byte(input int sel, output logic [7:0] data, output int idle,
                         output int ferr, output int start_cyc);
    int cpb;
    logic first;
    logic seen;
    cpb = (sel != 0) ? 868 : 4;
    idle = 0; ferr = 0; data = '0; start_cyc = 0; seen = 1'b0;
    while (!seen && idle < 20000) begin
      @(negedge clk);
      if (line_of(sel) === 1'b0) seen = 1'b1;
      else idle++;
    end
    if (!seen) begin
      ferr = 2;
      return;
    end
    start_cyc = cyc;
    repeat (cpb - 1) begin
      @(negedge clk);
      if (line_of(sel) !== 1'b0) ferr = 1;
    end
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      first = line_of(sel);
      data[b] = first;
      repeat (cpb - 1) begin
        @(negedge clk);
        if (line_of(sel) !== first) ferr = 1;
      end
    end
    repeat (cpb) begin
      @(negedge clk);
      if (line_of(sel) !== 1'b1) ferr = 1;
    end
  endtask

  task automatic capture_report(input int sel, input int nbytes);
    logic [7:0] d;
    int id, fe, sc;
    for (int i = 0; i < 10; i++) begin
      got[i] = 'x; gidle[i] = -1; gferr[i] = -1;
    end
    for (int i = 0; i < nbytes; i++) begin
      rx_byte(sel, d, id, fe, sc);
      got[i] = d; gidle[i] = id; gferr[i] = fe;
      if (i == 0) begin
        t_first = sc;
        busy_first = (sel != 0) ? busy_b : busy_a;
      end
      if (fe == 2) break;
    end
    @(negedge clk);
    rd_at_done = (sel != 0) ? rd_b : rd_a;
    t_done = cyc;
    @(negedge clk);
    rd_after = (sel != 0) ? rd_b : rd_a;
    busy_after = (sel != 0) ? busy_b : busy_a;
  endtask

  task automatic test_reset();
    int bad;
    rst_a = 1'b1; rst_b = 1'b1; done_a = 1'b0; done_b = 1'b0;
    cnt_a = '0; cnt_b = '0;
    repeat (3) @(negedge clk);
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
    checks++; if (rd_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", rd_a); end
    checks++; if (tx_b !== 1'b1) begin errors++; $display("FAIL reset_tx_b got %b want 1", tx_b); end
    rst_a = 1'b0; rst_b = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || rd_a !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL reset_idle bad_cycles %0d want 0", bad); end
  endtask

  task automatic test_basic();
    logic [7:0] exp [10];
    int p0;
    exp = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    done_a = 1'b0; cnt_a = 32'h0000ABCD;
    repeat (2) @(negedge clk);
    p0 = rd_pulses;
    done_a = 1'b1;
    capture_report(0, 10);
    for (int i = 0; i < 10; i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL basic_byte%0d got %h want %h", i, got[i], exp[i]); end
      checks++; if (gferr[i] != 0) begin errors++; $display("FAIL basic_frame%0d got %0d want 0", i, gferr[i]); end
      checks++; if (gidle[i] != 2) begin errors++; $display("FAIL basic_gap%0d got %0d want 2", i, gidle[i]); end
    end
    checks++; if (busy_first !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy_first); end
    checks++; if (t_done - t_first != 418) begin errors++; $display("FAIL basic_len got %0d want 418", t_done - t_first); end
    checks++; if (rd_at_done !== 1'b1) begin errors++; $display("FAIL basic_done_pulse got %b want 1", rd_at_done); end
    checks++; if (rd_after !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", rd_after); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy_after); end
    checks++; if (rd_pulses - p0 != 1) begin errors++; $display("FAIL basic_pulses got %0d want 1", rd_pulses - p0); end
  endtask

  task automatic test_extremes();
    logic [7:0] e1 [10];
    logic [7:0] e2 [10];
    e1 = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
    e2 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A};
    done_a = 1'b0; cnt_a = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    done_a = 1'b1;
    capture_report(0, 10);
    for (int i = 0; i < 10; i++) begin
      checks++; if (got[i] !== e1[i] || gferr[i] != 0) begin errors++; $display("FAIL ones_byte%0d got %h frame %0d want %h", i, got[i], gferr[i], e1[i]); end
    end
    done_a = 1'b0; cnt_a = 32'h12345678;
    repeat (2) @(negedge clk);
    done_a = 1'b1;
    capture_report(0, 10);
    for (int i = 0; i < 10; i++) begin
      checks++; if (got[i] !== e2[i] || gferr[i] != 0) begin errors++; $display("FAIL seq_byte%0d got %h frame %0d want %h", i, got[i], gferr[i], e2[i]); end
    end
    checks++; if (t_done - t_first != 418) begin errors++; $display("FAIL seq_len got %0d want 418", t_done - t_first); end
  endtask

  task automatic test_latch_hold();
    logic [7:0] exp [10];
    int p0, bad;
    exp = '{8'h31, 8'h33, 8'h35, 8'h37, 8'h39, 8'h42, 8'h44, 8'h46, 8'h0D, 8'h0A};
    done_a = 1'b0; cnt_a = 32'h13579BDF;
    repeat (2) @(negedge clk);
    p0 = rd_pulses;
    done_a = 1'b1;
    fork
      capture_report(0, 10);
      begin
        repeat (100) @(negedge clk);
        cnt_a = 32'hDEADBEEF;
        done_a = 1'b0;
        @(negedge clk);
        done_a = 1'b1;
      end
    join
    for (int i = 0; i < 10; i++) begin
      checks++; if (got[i] !== exp[i] || gferr[i] != 0) begin errors++; $display("FAIL latch_byte%0d got %h frame %0d want %h", i, got[i], gferr[i], exp[i]); end
    end
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_no_rerun bad_cycles %0d want 0", bad); end
    checks++; if (rd_pulses - p0 != 1) begin errors++; $display("FAIL hold_pulses got %0d want 1", rd_pulses - p0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [10];
    exp = '{8'h30, 8'h46, 8'h31, 8'h45, 8'h32, 8'h44, 8'h33, 8'h43, 8'h0D, 8'h0A};
    done_a = 1'b0; cnt_a = 32'h0F1E2D3C;
    repeat (2) @(negedge clk);
    done_a = 1'b1;
    repeat (185) @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", busy_a); end
    rst_a = 1'b1;
    @(negedge clk);
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL mid_tx got %b want 1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy_a); end
    checks++; if (rd_a !== 1'b0) begin errors++; $display("FAIL mid_done got %b want 0", rd_a); end
    @(negedge clk);
    rst_a = 1'b0;
    capture_report(0, 10);
    for (int i = 0; i < 10; i++) begin
      checks++; if (got[i] !== exp[i] || gferr[i] != 0) begin errors++; $display("FAIL resend_byte%0d got %h frame %0d want %h", i, got[i], gferr[i], exp[i]); end
    end
    checks++; if (gidle[0] != 2) begin errors++; $display("FAIL resend_start got %0d want 2", gidle[0]); end
    checks++; if (rd_at_done !== 1'b1) begin errors++; $display("FAIL resend_done got %b want 1", rd_at_done); end
  endtask

  task automatic test_bit_timing_868();
    done_b = 1'b0; cnt_b = 32'h55000000;
    repeat (2) @(negedge clk);
    done_b = 1'b1;
    capture_report(1, 2);
    for (int i = 0; i < 2; i++) begin
      checks++; if (got[i] !== 8'h35) begin errors++; $display("FAIL slow_byte%0d got %h want 35", i, got[i]); end
      checks++; if (gferr[i] != 0) begin errors++; $display("FAIL slow_frame%0d got %0d want 0", i, gferr[i]); end
      checks++; if (gidle[i] != 2) begin errors++; $display("FAIL slow_gap%0d got %0d want 2", i, gidle[i]); end
    end
    checks++; if (busy_after !== 1'b1) begin errors++; $display("FAIL slow_busy got %b want 1", busy_after); end
    rst_b = 1'b1;
    @(negedge clk);
    checks++; if (tx_b !== 1'b1 || busy_b !== 1'b0) begin errors++; $display("FAIL slow_reset tx %b busy %b want 1 0", tx_b, busy_b); end
    rst_b = 1'b0; done_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_latch_hold();
    test_reset_mid();
    test_bit_timing_868();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_perf_uart_reporter.md
Name: riscv_perf_uart_reporter

Overview:
Consumer side of the performance-counter result interface. Watches measurement_done_i and, on its rising edge, latches cycle_count_i. It then transmits the value over a UART TX line as 8 uppercase ASCII hex digits, MSB nibble first, followed by CR and LF. It sits between the performance counter and the board UART pin, so the host can read the matmul cycle count without a debugger.

Parameters:
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 2 or more.
- NUM_DIGITS, default 8: hex digits sent. Fixed at 8 for a 32-bit count; this is a localparam, not user-overridable.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  reset.
- cycle_count_i  input  32  count value from the performance counter.
- measurement_done_i  input  1  level, sticky-high when the measurement is complete.
- uart_tx_o  output  1  serial line, idle high.
- busy_o  output  1  high while a report is in progress.
- report_done_o  output  1  one-cycle pulse after the final LF stop bit.

Interface (already decided):
- One clock, clk_i.
- Reset reset_i is synchronous and active-high.

Behaviour:
- Reset values:
  - uart_tx_o=1, busy_o=0, report_done_o=0.
  - The edge-detect register done_q=0.
  - The byte index and the bit and baud counters are 0. State is IDLE.
- Edge detect:
  - done_q <= measurement_done_i every cycle.
  - The trigger is measurement_done_i & ~done_q, evaluated only in IDLE.
  - A rising edge while not in IDLE is ignored and is not queued.
- Top FSM:
  - IDLE: on trigger at edge N, latch cycle_count_i into cnt_q, set byte_idx=0, busy_o=1, and go to LOAD.
  - LOAD: present byte[byte_idx] to the TX sub-module with a 1-cycle start pulse, then go to SEND.
  - SEND: wait for tx_done.
    - If byte_idx==9, go to FIN.
    - Otherwise increment byte_idx and go to LOAD.
  - FIN: pulse report_done_o=1 for one cycle, set busy_o=0, and go to IDLE.
- Byte map:
  - Indices 0..7 carry nibble cnt_q[31-4k -: 4]. 0-9 maps to 0x30-0x39; A-F maps to 0x41-0x46.
  - Index 8 is 0x0D. Index 9 is 0x0A.
- UART frame:
  - Start bit 0, 8 data bits LSB first, 1 stop bit.
  - Each bit is held exactly CLKS_PER_BIT cycles, giving 10*CLKS_PER_BIT cycles per byte.
- Timing:
  - uart_tx_o first goes low at edge N+2.
  - tx_done asserts in the last stop-bit cycle.
  - The next start bit begins 2 cycles after the prior stop bit ends (idle-high gap of 2 cycles).
  - Total report length is 10*(10*CLKS_PER_BIT) + 9*2 cycles from the first start bit to the end of the LF stop bit.
  - report_done_o is asserted in the cycle after the LF stop bit ends.
- Data stability: cnt_q is frozen for the whole report. Changes on cycle_count_i after edge N have no effect.
- measurement_done_i behaviour:
  - Held high forever: exactly one report.
  - Must fall and rise again to start a new report. A rise landing on the FIN cycle is missed.
- Reset mid-operation: at the reset edge all outputs return to reset values. uart_tx_o is high the cycle after reset is sampled, and no partial byte completes.
- Reset while measurement_done_i is held high: done_q resets to 0, so the first cycle after reset release sees a rising edge and a fresh report is sent. This is intentional, so that a report is re-sent after a board reset.

Decomposition:
- Shared package riscv_perf_pkg holds:
  - state encodings IDLE/LOAD/SEND/FIN;
  - ASCII_CR=8'h0D and ASCII_LF=8'h0A;
  - REPORT_BYTES=10;
  - the nibble-to-ASCII function.
- One sub-module, uart_tx_byte:
  - Parameter CLKS_PER_BIT.
  - Inputs clk_i, reset_i, start_i, data_i[7:0].
  - Outputs tx_o, busy_o, done_o.
  - Own FSM: IDLE, START, DATA, STOP, with a baud counter and a 3-bit bit index.
  - start_i is ignored while busy.

Test Plan:
- Reset check: assert reset_i for 3 cycles with measurement_done_i=0 -> uart_tx_o=1, busy_o=0, report_done_o=0. The line stays idle for 1000 cycles.
- Basic report (CLKS_PER_BIT=4): cycle_count_i=32'h0000ABCD, raise measurement_done_i -> decoded bytes 30 30 30 30 41 42 43 44 0D 0A. First start bit at N+2. report_done_o pulses once, after 418 cycles.
- Digit extremes: cycle_count_i=32'hFFFFFFFF -> 46×8, 0D, 0A. Then re-trigger with 32'h12345678 -> 31 32 33 34 35 36 37 38 0D 0A.
- Latch and hold:
  - Change cycle_count_i to 32'hDEADBEEF during byte 2 -> transmitted value is still the original.
  - Keep measurement_done_i high after report_done_o -> no second report.
  - Toggle 0→1 while busy_o=1 -> ignored.
- Reset mid-byte: assert reset_i during the data bits of byte 4 -> uart_tx_o=1 and busy_o=0 next cycle. With measurement_done_i still high after release, a new complete 10-byte report follows.
- Bit timing: measure every bit width at CLKS_PER_BIT=4 and at 868 -> exactly CLKS_PER_BIT cycles per bit, and an inter-byte idle gap of exactly 2 cycles.
